// File: rtl/i2s_pkg.sv
// Shared I2S transmit parameters and types.
// Frame geometry is derived from the slot width.
package i2s_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int SLOT_W          = 32;
  localparam int FRAME_HALF_BITS = 4 * SLOT_W;
  localparam int HCNT_W          = $clog2(FRAME_HALF_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/i2s_tx.sv
// I2S serializer: one stereo frame per sample, MSB first, one-BCLK delay.
// Define I2S_TX_STEREO_EN for a separate right channel; otherwise mono.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = i2s_pkg::SAMPLE_W,
  parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
  input  logic                       master_clk,
  input  logic                       rst,
  input  logic                       sample_clk_en,
  input  logic                       bit_clk_en,
  input  logic signed [SAMPLE_W-1:0] sample_left,
`ifdef I2S_TX_STEREO_EN
  input  logic signed [SAMPLE_W-1:0] sample_right,
`endif
  output logic                       i2s_bclk,
  output logic                       i2s_lrclk,
  output logic                       i2s_sdata,
  output logic                       underrun
);

  localparam int FHB = 4 * SLOT_W;
  localparam int HW  = $clog2(FHB);
  localparam int BW  = HW - 1;
  localparam int IW  = $clog2(SAMPLE_W);

  localparam logic [HW-1:0] HLAST  = HW'(FHB - 1);
  localparam logic [BW-1:0] SLOT_B = BW'(SLOT_W);
  localparam logic [BW-1:0] SAMP_B = BW'(SAMPLE_W);
  localparam logic [IW-1:0] SAMP_I = IW'(SAMPLE_W);

  i2s_state_t state_q, state_d;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          fresh_q, fresh_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          undr_q, undr_d;

  logic signed [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic signed [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic signed [SAMPLE_W-1:0] frm_l_q, frm_l_d;
  logic signed [SAMPLE_W-1:0] frm_r_q, frm_r_d;

  logic signed [SAMPLE_W-1:0] in_r;
  logic signed [SAMPLE_W-1:0] chan;
  logic [BW-1:0]              b;
  logic [BW-1:0]              s;
  logic [IW-1:0]              idx;
  logic                       lr;
  logic                       sd;

`ifdef I2S_TX_STEREO_EN
  assign in_r = sample_right;
`else
  assign in_r = sample_left;
`endif

  // Slot decode: bit s of a slot carries sample bit SAMPLE_W-s.
  always_comb begin
    b    = hcnt_q[HW-1:1];
    lr   = (b >= SLOT_B);
    s    = lr ? (b - SLOT_B) : b;
    idx  = SAMP_I - s[IW-1:0];
    chan = lr ? frm_r_q : frm_l_q;
    sd   = 1'b0;
    if ((s != '0) && (s <= SAMP_B)) begin
      sd = chan[idx];
    end
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    fresh_d  = fresh_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    undr_d   = 1'b0;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    frm_l_d  = frm_l_q;
    frm_r_d  = frm_r_q;
    unique case (state_q)
      IDLE: begin
        hcnt_d  = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (sample_clk_en) begin
          state_d  = RUN;
          hold_l_d = sample_left;
          hold_r_d = in_r;
          frm_l_d  = sample_left;
          frm_r_d  = in_r;
          fresh_d  = 1'b0;
        end
      end
      RUN: begin
        if (sample_clk_en) begin
          hold_l_d = sample_left;
          hold_r_d = in_r;
          fresh_d  = 1'b1;
        end
        if (bit_clk_en) begin
          bclk_d  = hcnt_q[0];
          lrclk_d = lr;
          sdata_d = sd;
          hcnt_d  = (hcnt_q == HLAST) ? '0 : hcnt_q + 1'b1;
          if (hcnt_q == HLAST) begin
            fresh_d = 1'b0;
            // A coincident sample bypasses the holding register.
            if (sample_clk_en) begin
              frm_l_d = sample_left;
              frm_r_d = in_r;
            end else begin
              frm_l_d = hold_l_q;
              frm_r_d = hold_r_q;
              undr_d  = ~fresh_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      fresh_q  <= 1'b0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      undr_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      frm_l_q  <= '0;
      frm_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      fresh_q  <= fresh_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      undr_q   <= undr_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      frm_l_q  <= frm_l_d;
      frm_r_q  <= frm_r_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = undr_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed/random bench for i2s_tx against a frame-level reference model.
// Frames are modelled as 64-bit serial words {0,L,pad,0,R,pad}.
module tb_i2s_tx;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sce = 1'b0;
  logic               bce = 1'b0;
  logic signed [15:0] sl  = '0;
  logic signed [15:0] sr  = '0;
  logic               bclk, lrclk, sdata, und;

  always #5 clk = ~clk;

  i2s_tx dut (
    .master_clk   (clk),
    .rst          (rst),
    .sample_clk_en(sce),
    .bit_clk_en   (bce),
    .sample_left  (sl),
`ifdef I2S_TX_STEREO_EN
    .sample_right (sr),
`endif
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_sdata    (sdata),
    .underrun     (und)
  );

  int n    = 0;
  int errs = 0;

  bit          armed = 0;
  int          pos   = 0;
  logic [15:0] curL  = '0, curR = '0;
  logic [15:0] holdL = '0, holdR = '0;
  bit          fresh = 0;
  logic        eB = 0, eL = 0, eS = 0, eU = 0;

  logic [31:0] capL, capR;
  logic        pb;
  int          und_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic fbit(input logic [15:0] l, input logic [15:0] r,
                                input int p);
    logic [63:0] fv;
    fv = {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    return fv[63 - p / 2];
  endfunction

  function automatic logic [31:0] slot(input logic [15:0] v);
    return {1'b0, v, 15'b0};
  endfunction

  task automatic model_reset();
    armed = 0; pos = 0; fresh = 0;
    curL = '0; curR = '0; holdL = '0; holdR = '0;
    eB = 0; eL = 0; eS = 0; eU = 0;
  endtask

  function automatic logic [15:0] rmap(input logic [15:0] l,
                                       input logic [15:0] r);
`ifdef I2S_TX_STEREO_EN
    return r;
`else
    return l;
`endif
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, "_bclk"},  32'(bclk),  32'(eB));
    chk({tag, "_lrclk"}, 32'(lrclk), 32'(eL));
    chk({tag, "_sdata"}, 32'(sdata), 32'(eS));
    chk({tag, "_undr"},  32'(und),   32'(eU));
  endtask

  task automatic sample(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] rr;
    rr = rmap(l, r);
    eU = 0;
    if (!armed) begin
      armed = 1; pos = 0; fresh = 0;
      curL = l; curR = rr; holdL = l; holdR = rr;
    end else begin
      holdL = l; holdR = rr; fresh = 1;
    end
    sce = 1; bce = 0; sl = l; sr = r;
    @(posedge clk); #1;
    sce = 0;
    chk_out("smp");
  endtask

  task automatic bitstep(input bit s, input logic [15:0] l,
                         input logic [15:0] r);
    logic [15:0] rr;
    rr = rmap(l, r);
    eU = 0;
    if (armed) begin
      eB = pos[0];
      eL = (pos >= 64);
      eS = fbit(curL, curR, pos);
      if (pos == 127) begin
        if (s) begin
          curL = l; curR = rr; holdL = l; holdR = rr;
        end else begin
          curL = holdL; curR = holdR; eU = !fresh;
        end
        fresh = 0;
      end else if (s) begin
        holdL = l; holdR = rr; fresh = 1;
      end
      pos = (pos + 1) % 128;
    end else if (s) begin
      armed = 1; pos = 0; fresh = 0;
      curL = l; curR = rr; holdL = l; holdR = rr;
    end
    sce = s; bce = 1; sl = l; sr = r;
    @(posedge clk); #1;
    sce = 0; bce = 0;
    chk_out("bit");
    if (und) und_cnt++;
    if (bclk && !pb) begin
      if (lrclk) capR = {capR[30:0], sdata};
      else       capL = {capL[30:0], sdata};
    end
    pb = bclk;
    @(posedge clk); #1;
    eU = 0;
    chk("pulse_end", 32'(und), 32'(0));
    chk("hold_bclk", 32'(bclk), 32'(eB));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One full frame from pos 0; a sample strobe lands at step 'at' (<0: none).
  task automatic frame(input int at, input logic [15:0] l,
                       input logic [15:0] r);
    capL = '0; capR = '0; pb = bclk;
    for (int i = 0; i < 128; i++) bitstep(i == at, l, r);
  endtask

  logic [15:0] x, y, z, w;
  logic [15:0] fl, fr;

  initial begin
    und_cnt = 0; capL = '0; capR = '0; pb = 0;
    #1;
    // Reset with random strobes
    for (int i = 0; i < 2; i++) begin
      rst = 1; sce = 1'($urandom); bce = 1'($urandom); sl = 16'($urandom);
      @(posedge clk); #1;
      model_reset();
      chk_out("rst");
    end
    rst = 0; sce = 0; bce = 0;
    for (int i = 0; i < 10; i++) bitstep(0, 16'h0, 16'h0);

    // Mono pattern A5C3
    x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
    sample(16'hA5C3, 16'hA5C3);
    frame(40, x, x);
    chk("a5c3_left",  capL, slot(16'hA5C3));
    chk("a5c3_right", capR, slot(16'hA5C3));

    // Underrun: frame carrying x gets no fresh sample
    und_cnt = 0;
    frame(-1, 16'h0, 16'h0);
    chk("x_left", capL, slot(x));
    frame(50, y, y);
    chk("x_repeat", capL, slot(x));
    frame(60, z, z);
    chk("y_left", capL, slot(y));
    chk("und_once", 32'(und_cnt), 32'(1));

    // Coincident strobe on the load step
    frame(127, 16'h1234, 16'h1234);
    chk("z_left", capL, slot(z));
    w = 16'($urandom);
    frame(30, w, w);
    chk("coin_left", capL, slot(16'h1234));
    chk("coin_noundr", 32'(und_cnt), 32'(1));

    // Random frames
    for (int k = 0; k < 3; k++) begin
      fl = curL; fr = curR;
      x = 16'($urandom); y = 16'($urandom);
      frame(int'($urandom_range(0, 126)), x, y);
      chk("rnd_left",  capL, slot(fl));
      chk("rnd_right", capR, slot(fr));
    end

`ifdef I2S_TX_STEREO_EN
    frame(127, 16'h8000, 16'h7FFF);
    frame(10, 16'h0, 16'h0);
    chk("st_left",  capL, slot(16'h8000));
    chk("st_right", capR, slot(16'h7FFF));
`endif

    // Mid-frame reset at hcnt 70
    while (pos != 70) bitstep(0, 16'h0, 16'h0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    chk_out("midrst");
    bitstep(0, 16'h0, 16'h0);
    sample(16'h0001, 16'h0001);
    frame(20, 16'h0, 16'h0);
    chk("rearm_left", capL, slot(16'h0001));
    chk("rearm_right", capR, slot(16'h0001));

    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serializes 16-bit signed NCO samples onto an I2S bus (BCLK, LRCLK, SDATA) for the audio DAC. It sits downstream of `nco` and consumes the `sample_clk_en` and `bit_clk_en` strobes from `clk_div`, all in the `master_clk` domain (24.576 MHz). The block is the transmit end of the sample path: the NCO produces one sample per `sample_clk_en`, and this block ships it as one stereo I2S frame of 2×32 BCLK periods.

## Interface
- `SAMPLE_W`, 16: sample width; must be < `SLOT_W`.
- `SLOT_W`, 32: BCLK periods per channel slot; frame = 2×`SLOT_W` BCLK periods = 4×`SLOT_W` half-periods.
- `master_clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_clk_en`  in  1  one-cycle strobe, once per frame; marks a valid `sample_left`/`sample_right`.
- `bit_clk_en`  in  1  one-cycle strobe at 2×BCLK rate; each strobe advances one BCLK half-period.
- `sample_left`  in  `SAMPLE_W` signed  left or mono sample; `nco.sample_output` connects here.
- `sample_right`  in  `SAMPLE_W` signed  right sample; present only with `I2S_TX_STEREO_EN`.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select; 0 = left, 1 = right.
- `i2s_sdata`  out  1  serial data, MSB first.
- `underrun`  out  1  one-cycle pulse when a frame loads with no fresh sample.

## Operation
- **Holding registers.** `hold_l`/`hold_r` capture the inputs on every `sample_clk_en`. A `fresh` flag is set on capture and cleared on frame load.
- **States.**
  - IDLE: all outputs 0, half-period counter `hcnt` held at 0.
  - IDLE→RUN: first `sample_clk_en`. That cycle loads the frame registers `frm_l`/`frm_r` directly from the inputs, sets `hcnt`=0 and clears `fresh`.
  - RUN never exits except on `rst`.
- **Per `bit_clk_en` in RUN:**
  - Drive the outputs from the current `hcnt`, then increment `hcnt` (wraps at 4×`SLOT_W`−1).
  - BCLK period index `b`=`hcnt`>>1; slot bit `s`=`b` mod `SLOT_W`.
  - `i2s_bclk`=`hcnt`[0].
  - `i2s_lrclk`=(`b` ≥ `SLOT_W`).
  - `i2s_sdata`=channel bit [`SAMPLE_W`−`s`] for `s` in 1..`SAMPLE_W`, otherwise 0. This gives the standard I2S one-BCLK delay, MSB first and zero padding.
  - Channel is `frm_r` when `i2s_lrclk`=1, else `frm_l`.
  - Data and LRCLK therefore change only on BCLK falling edges (even `hcnt`).
- **Frame load** (on the `bit_clk_en` where `hcnt`=4×`SLOT_W`−1, after driving outputs):
  - `frm_*`←`hold_*`, then `fresh` is cleared.
  - If `fresh` was 0, `underrun`=1 for that cycle and the previous sample is repeated.
- **Simultaneous `sample_clk_en` and frame load:** the incoming sample bypasses into `frm_*`, `hold_*` is updated too, no underrun is signalled, and `fresh` ends cleared.
- `sample_clk_en` arriving mid-frame only updates `hold_*` and sets `fresh`; the frame in flight is unaffected.
- `bit_clk_en` in IDLE is ignored.

## Timing
- Reset values: `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_sdata`=0, `underrun`=0, state IDLE, `hcnt`=0, `hold_*`=0, `frm_*`=0, `fresh`=0.
- All outputs are registered and update one `master_clk` after the qualifying `bit_clk_en`, then hold until the next one.
- Latency: a sample captured at arming appears as the left MSB on the 3rd `bit_clk_en` after arming (`hcnt`=2).
- Nominal rates (24.576 MHz, `bit_clk_en` every 4 clocks): BCLK 3.072 MHz, 128 `bit_clk_en` per frame, frame rate 48 kHz.
- `rst` mid-frame: all outputs go to 0 on the next edge and the block returns to IDLE. It re-arms on the next `sample_clk_en`.

## Configuration
- `I2S_TX_STEREO_EN` defined: the `sample_right` port exists, and `hold_r`/`frm_r` are loaded from it.
- Undefined: no `sample_right` port. `hold_r`/`frm_r` mirror the left path, so the mono NCO sample appears identically in both slots.

## Structure
- Shared package `i2s_pkg`:
  - `SAMPLE_W` and `SLOT_W` defaults.
  - Derived `FRAME_HALF_BITS`=4×`SLOT_W` and `HCNT_W`=$clog2(`FRAME_HALF_BITS`).
  - Typedef `i2s_state_t` {IDLE, RUN}.
- Single flat module; no sub-module. Slot/bit decoding is a few lines of combinational logic.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with random strobes → all outputs 0; IDLE persists through 10 `bit_clk_en` with no `sample_clk_en`.
- **Mono serialization:** `sample_left`=16'hA5C3 at arming → SDATA sampled on BCLK rises gives:
  - LRCLK=0: 0, 1010010111000011, then 15 zeros.
  - LRCLK=1: the same pattern.
- **Stereo** (`I2S_TX_STEREO_EN`): L=16'h8000, R=16'h7FFF → left slot bit1=1 with the rest 0; right slot bits1..16: 0 followed by fifteen 1s.
- **Underrun:** suppress one `sample_clk_en` after arming → exactly one `underrun` pulse at the 2nd frame load (the 1st is fed by that frame's own `sample_clk_en`), and the previous sample is repeated; no pulse once strobes resume.
- **Coincident strobe:** `sample_clk_en` on the frame-load cycle with value 16'h1234 → the next frame carries 16'h1234 and no `underrun`.
- **Mid-frame reset:** `rst` at `hcnt`=70 → outputs 0 next cycle; re-arm with 16'h0001 → the left slot's LSB (bit16) is 1 and all other bits are 0.
